// File: rtl/ctrl_flow_seq_pkg.sv
// Shared types and constants for the control-flow frame sequencer.
package ctrl_flow_seq_pkg;

    // Decoded control instruction
    typedef enum logic [3:0] {
        OP_BLOCK  = 4'd0,
        OP_LOOP   = 4'd1,
        OP_IF     = 4'd2,
        OP_ELSE   = 4'd3,
        OP_END    = 4'd4,
        OP_BR     = 4'd5,
        OP_BR_IF  = 4'd6,
        OP_CALL   = 4'd7,
        OP_RETURN = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StUnwind,
        StTarget
    } seq_state_e;

    // Frame type field encodings
    localparam logic [1:0] FT_BLOCK = 2'b00;
    localparam logic [1:0] FT_CALL  = 2'b01;
    localparam logic [1:0] FT_IF    = 2'b10;
    localparam logic [1:0] FT_LOOP  = 2'b11;

    // Frame word layout, LSB first: addr, sp_tag, ret_num, type[1:0]
    localparam int unsigned FRAME_ADDR_LSB = 0;

    function automatic int unsigned frame_sp_lsb(int unsigned pc_w);
        return pc_w;
    endfunction

    function automatic int unsigned frame_ret_bit(int unsigned st_w, int unsigned pc_w);
        return pc_w + st_w;
    endfunction

    function automatic int unsigned frame_type_lsb(int unsigned st_w, int unsigned pc_w);
        return pc_w + st_w + 1;
    endfunction

endpackage

// File: rtl/ctrl_flow_seq_frame_pack.sv
// Combinational pack of a new frame word and unpack of the current top frame.
module ctrl_frame_pack
    import ctrl_flow_seq_pkg::*;
#(
    parameter int unsigned ST_W    = 6,
    parameter int unsigned PC_W    = 21,
    parameter int unsigned FRAME_W = 3 + ST_W + PC_W
) (
    input  logic [1:0]         pk_type,
    input  logic               pk_ret_num,
    input  logic [ST_W-1:0]    pk_sp,
    input  logic [PC_W-1:0]    pk_addr,
    output logic [FRAME_W-1:0] pk_frame,
    input  logic [FRAME_W-1:0] up_frame,
    output logic [1:0]         up_type,
    output logic               up_ret_num,
    output logic [ST_W-1:0]    up_sp,
    output logic [PC_W-1:0]    up_addr
);

    localparam int unsigned SP_LSB   = frame_sp_lsb(PC_W);
    localparam int unsigned RET_BIT  = frame_ret_bit(ST_W, PC_W);
    localparam int unsigned TYPE_LSB = frame_type_lsb(ST_W, PC_W);

    // Assemble the frame to push
    always_comb begin
        pk_frame                         = '0;
        pk_frame[FRAME_ADDR_LSB +: PC_W] = pk_addr;
        pk_frame[SP_LSB +: ST_W]         = pk_sp;
        pk_frame[RET_BIT]                = pk_ret_num;
        pk_frame[TYPE_LSB +: 2]          = pk_type;
    end

    // Split the top-of-stack frame into fields
    always_comb begin
        up_addr    = up_frame[FRAME_ADDR_LSB +: PC_W];
        up_sp      = up_frame[SP_LSB +: ST_W];
        up_ret_num = up_frame[RET_BIT];
        up_type    = up_frame[TYPE_LSB +: 2];
    end

endmodule

// File: rtl/ctrl_flow_seq.sv
// Control-flow sequencer: turns decoded control ops into frame stack strobes,
// multi-cycle br unwinding, PC redirects and value-stack-pointer restores.
module ctrl_flow_seq
    import ctrl_flow_seq_pkg::*;
#(
    parameter int unsigned ST_W    = 6,
    parameter int unsigned PC_W    = 21,
    parameter int unsigned DEPTH_W = 6,
    parameter int unsigned FRAME_W = 3 + ST_W + PC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  op_e                in_op,
    input  logic [DEPTH_W-1:0] in_depth,
    input  logic               in_cond,
    input  logic               in_ret_num,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [PC_W-1:0]    in_target,
    input  logic [ST_W-1:0]    in_sp,
    output logic               cs_shift_vld,
    output logic               cs_push,
    output logic               cs_pop,
    output logic               cs_retu,
    output logic               cs_call,
    output logic [FRAME_W-1:0] cs_push_data,
    input  logic [FRAME_W-1:0] cs_top_data,
    output logic               redir_vld,
    output logic [PC_W-1:0]    redir_pc,
    output logic               sp_vld,
    output logic [ST_W-1:0]    sp_restore,
    output logic               halt,
    output logic               err
);

    localparam int unsigned OCC_W      = DEPTH_W + 1;
    localparam int unsigned NUM_FRAMES = 2 ** DEPTH_W;
    localparam logic [OCC_W-1:0] OCC_FULL = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    seq_state_e             state_q;
    logic                   armed_q;
    logic [OCC_W-1:0]       occ_q;
    logic [DEPTH_W-1:0]     unwind_q;
    // One bit per stack slot: slot holds a function (call) frame
    logic [NUM_FRAMES-1:0]  call_map_q;
    op_e                    op_q;
    logic                   cond_q;
    logic                   ret_num_q;
    logic [PC_W-1:0]        pc_q;
    logic [PC_W-1:0]        target_q;
    logic [ST_W-1:0]        sp_q;

    logic                   is_push_op;
    logic                   is_label_op;
    logic                   is_branch;
    logic                   bad_op;
    logic [DEPTH_W-1:0]     depth_eff;
    logic                   has_func;
    logic [DEPTH_W-1:0]     func_idx;
    logic [1:0]             pk_type;
    logic [PC_W-1:0]        pk_addr;
    logic [1:0]             top_type;
    logic                   top_ret_num;
    logic [ST_W-1:0]        top_sp;
    logic [PC_W-1:0]        top_addr;
    logic [ST_W-1:0]        top_restore;

    ctrl_frame_pack #(
        .ST_W    (ST_W),
        .PC_W    (PC_W),
        .FRAME_W (FRAME_W)
    ) u_frame_pack (
        .pk_type    (pk_type),
        .pk_ret_num (ret_num_q),
        .pk_sp      (sp_q),
        .pk_addr    (pk_addr),
        .pk_frame   (cs_push_data),
        .up_frame   (cs_top_data),
        .up_type    (top_type),
        .up_ret_num (top_ret_num),
        .up_sp      (top_sp),
        .up_addr    (top_addr)
    );

    // sp_tag + ret_num wraps at ST_W bits
    assign top_restore = top_sp + ST_W'(top_ret_num);

    // Ready only once out of reset, idle and not halted
    assign in_rdy = armed_q && (state_q == StIdle) && !halt;

    // Innermost live function frame: highest call slot below occ
    always_comb begin
        has_func = 1'b0;
        func_idx = '0;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            if (call_map_q[i] && (OCC_W'(i) < occ_q)) begin
                has_func = 1'b1;
                func_idx = DEPTH_W'(i);
            end
        end
    end

    // Classify the offered instruction and detect stack violations up front
    always_comb begin
        is_push_op  = (in_op == OP_BLOCK) || (in_op == OP_LOOP) ||
                      (in_op == OP_IF)    || (in_op == OP_CALL);
        is_label_op = (in_op == OP_BR) || (in_op == OP_BR_IF) || (in_op == OP_ELSE);
        is_branch   = (in_op == OP_BR) || (in_op == OP_ELSE) || ((in_op == OP_BR_IF) && in_cond);
        // else is a br 0 out of the if frame
        depth_eff   = (in_op == OP_ELSE) ? '0 : in_depth;
        // br_if label is checked even when not taken: the label is invalid either way
        bad_op      = (is_push_op && (occ_q == OCC_FULL)) ||
                      ((in_op == OP_END) && (occ_q == '0)) ||
                      ((in_op == OP_RETURN) && !has_func) ||
                      (is_label_op && ({1'b0, depth_eff} >= occ_q));
    end

    // Frame stack strobes decode from the current state and latched op
    always_comb begin
        cs_push = 1'b0;
        cs_pop  = 1'b0;
        cs_retu = 1'b0;
        cs_call = 1'b0;
        pk_type = FT_BLOCK;
        pk_addr = target_q;
        unique case (state_q)
            StExec: begin
                unique case (op_q)
                    OP_BLOCK: begin
                        cs_push = 1'b1;
                    end
                    OP_LOOP: begin
                        cs_push = 1'b1;
                        pk_type = FT_LOOP;
                        pk_addr = pc_q;
                    end
                    OP_IF: begin
                        cs_push = 1'b1;
                        pk_type = FT_IF;
                    end
                    OP_CALL: begin
                        cs_push = 1'b1;
                        cs_call = 1'b1;
                        pk_type = FT_CALL;
                        pk_addr = pc_q;
                    end
                    OP_END:    cs_pop  = 1'b1;
                    OP_RETURN: cs_retu = 1'b1;
                    default: ;
                endcase
            end
            StUnwind: cs_pop = 1'b1;
            // Branching to a loop re-enters it, so its frame stays
            StTarget: cs_pop = (top_type != FT_LOOP);
            default: ;
        endcase
        cs_shift_vld = cs_push || cs_pop || cs_retu;
    end

    // Sequencer FSM with registered redirect/SP pulses and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            armed_q    <= 1'b0;
            occ_q      <= '0;
            unwind_q   <= '0;
            call_map_q <= '0;
            op_q       <= OP_BLOCK;
            cond_q     <= 1'b0;
            ret_num_q  <= 1'b0;
            pc_q       <= '0;
            target_q   <= '0;
            sp_q       <= '0;
            redir_vld  <= 1'b0;
            redir_pc   <= '0;
            sp_vld     <= 1'b0;
            sp_restore <= '0;
            halt       <= 1'b0;
            err        <= 1'b0;
        end else begin
            armed_q   <= 1'b1;
            redir_vld <= 1'b0;
            sp_vld    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_vld && in_rdy) begin
                        op_q      <= in_op;
                        cond_q    <= in_cond;
                        ret_num_q <= in_ret_num;
                        pc_q      <= in_pc;
                        target_q  <= in_target;
                        sp_q      <= in_sp;
                        if (bad_op) begin
                            err <= 1'b1;
                        end else if (is_branch) begin
                            unwind_q <= depth_eff;
                            state_q  <= (depth_eff != '0) ? StUnwind : StTarget;
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    state_q <= StIdle;
                    unique case (op_q)
                        OP_BLOCK, OP_LOOP, OP_IF, OP_CALL: begin
                            call_map_q[occ_q[DEPTH_W-1:0]] <= (op_q == OP_CALL);
                            occ_q <= occ_q + 1'b1;
                            if ((op_q == OP_CALL) || ((op_q == OP_IF) && !cond_q)) begin
                                redir_vld <= 1'b1;
                                redir_pc  <= target_q;
                            end
                        end
                        OP_END: begin
                            occ_q <= occ_q - 1'b1;
                            // Closing a function body behaves like return
                            if (top_type == FT_CALL) begin
                                redir_vld  <= 1'b1;
                                redir_pc   <= top_addr;
                                sp_vld     <= 1'b1;
                                sp_restore <= top_restore;
                                if (occ_q == OCC_ONE) begin
                                    halt <= 1'b1;
                                end
                            end
                        end
                        OP_RETURN: begin
                            occ_q      <= {1'b0, func_idx};
                            redir_vld  <= 1'b1;
                            redir_pc   <= top_addr;
                            sp_vld     <= 1'b1;
                            sp_restore <= top_restore;
                            if (func_idx == '0) begin
                                halt <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                StUnwind: begin
                    occ_q    <= occ_q - 1'b1;
                    unwind_q <= unwind_q - 1'b1;
                    if (unwind_q == DEPTH_W'(1)) begin
                        state_q <= StTarget;
                    end
                end
                StTarget: begin
                    if (top_type != FT_LOOP) begin
                        occ_q <= occ_q - 1'b1;
                    end
                    redir_vld  <= 1'b1;
                    redir_pc   <= top_addr;
                    sp_vld     <= 1'b1;
                    sp_restore <= top_restore;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_flow_seq.sv
// Directed bench for ctrl_flow_seq with a behavioural frame stack.
module tb_ctrl_flow_seq;
    import ctrl_flow_seq_pkg::*;

    localparam int ST_W    = 6;
    localparam int PC_W    = 21;
    localparam int DEPTH_W = 6;
    localparam int FRAME_W = 3 + ST_W + PC_W;

    logic               clk;
    logic               rst_n;
    logic               in_vld;
    logic               in_rdy;
    op_e                in_op;
    logic [DEPTH_W-1:0] in_depth;
    logic               in_cond;
    logic               in_ret_num;
    logic [PC_W-1:0]    in_pc;
    logic [PC_W-1:0]    in_target;
    logic [ST_W-1:0]    in_sp;
    logic               cs_shift_vld;
    logic               cs_push;
    logic               cs_pop;
    logic               cs_retu;
    logic               cs_call;
    logic [FRAME_W-1:0] cs_push_data;
    logic [FRAME_W-1:0] cs_top_data;
    logic               redir_vld;
    logic [PC_W-1:0]    redir_pc;
    logic               sp_vld;
    logic [ST_W-1:0]    sp_restore;
    logic               halt;
    logic               err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Frame stack model
    logic [FRAME_W-1:0] fs_mem [0:63];
    logic [6:0]         fs_ptr;
    logic [5:0]         fs_fidx;
    logic [5:0]         fs_top;

    ctrl_flow_seq #(
        .ST_W    (ST_W),
        .PC_W    (PC_W),
        .DEPTH_W (DEPTH_W),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_op        (in_op),
        .in_depth     (in_depth),
        .in_cond      (in_cond),
        .in_ret_num   (in_ret_num),
        .in_pc        (in_pc),
        .in_target    (in_target),
        .in_sp        (in_sp),
        .cs_shift_vld (cs_shift_vld),
        .cs_push      (cs_push),
        .cs_pop       (cs_pop),
        .cs_retu      (cs_retu),
        .cs_call      (cs_call),
        .cs_push_data (cs_push_data),
        .cs_top_data  (cs_top_data),
        .redir_vld    (redir_vld),
        .redir_pc     (redir_pc),
        .sp_vld       (sp_vld),
        .sp_restore   (sp_restore),
        .halt         (halt),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs_ptr <= '0;
        end else if (cs_shift_vld) begin
            if (cs_push) begin
                fs_mem[fs_ptr[5:0]] <= cs_push_data;
                fs_ptr <= fs_ptr + 7'd1;
            end else if (cs_pop) begin
                fs_ptr <= fs_ptr - 7'd1;
            end else if (cs_retu) begin
                fs_ptr <= {1'b0, fs_fidx};
            end
        end
    end

    always_comb begin
        fs_fidx = '0;
        for (int i = 0; i < 64; i++) begin
            if ((7'(i) < fs_ptr) && (fs_mem[i][FRAME_W-1 -: 2] == 2'b01)) fs_fidx = 6'(i);
        end
        fs_top = fs_ptr[5:0] - 6'd1;
        if (cs_retu) cs_top_data = fs_mem[fs_fidx];
        else if (fs_ptr != '0) cs_top_data = fs_mem[fs_top];
        else cs_top_data = '0;
    end

    task automatic do_reset();
        in_vld = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one op; returns just after the accepting clock edge
    task automatic send(input op_e op, input logic [5:0] depth, input logic cond,
                        input logic ret, input logic [20:0] pc, input logic [20:0] tgt,
                        input logic [5:0] sp);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            chk_cnt++;
            $display("FAIL send_rdy_timeout got in_rdy=%0b want 1", in_rdy);
        end
        in_op = op; in_depth = depth; in_cond = cond; in_ret_num = ret;
        in_pc = pc; in_target = tgt; in_sp = sp; in_vld = 1'b1;
        @(posedge clk);
        #1 in_vld = 1'b0;
    endtask

    task automatic test_reset();
        in_vld = 1'b0; in_op = OP_BLOCK; in_depth = '0; in_cond = 1'b0; in_ret_num = 1'b0;
        in_pc = '0; in_target = '0; in_sp = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL rst_rdy got %0b want 0", in_rdy); else pass_cnt++;
        chk_cnt++;
        if ({cs_shift_vld, redir_vld, sp_vld, halt, err} !== 5'b0)
            $display("FAIL rst_outs got %b want 00000", {cs_shift_vld, redir_vld, sp_vld, halt, err});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL rst_rel_rdy got %0b want 1", in_rdy); else pass_cnt++;
    endtask

    task automatic test_loop_br0();
        logic [FRAME_W-1:0] exp_f;
        exp_f = {2'b11, 1'b0, 6'd3, 21'h10};
        do_reset();
        send(OP_LOOP, 6'd0, 1'b0, 1'b0, 21'h10, 21'h0, 6'd3);
        @(negedge clk);
        chk_cnt++;
        if ({cs_shift_vld, cs_push} !== 2'b11) $display("FAIL loop_push got %b want 11", {cs_shift_vld, cs_push});
        else pass_cnt++;
        chk_cnt++; if (cs_push_data !== exp_f) $display("FAIL loop_frame got %h want %h", cs_push_data, exp_f); else pass_cnt++;
        chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL loop_busy got %0b want 0", in_rdy); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (redir_vld !== 1'b0) $display("FAIL loop_noredir got %0b want 0", redir_vld); else pass_cnt++;
        chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL loop_rdy_t2 got %0b want 1", in_rdy); else pass_cnt++;
        send(OP_BR, 6'd0, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        chk_cnt++; if (cs_shift_vld !== 1'b0) $display("FAIL br0_nopop got %0b want 0", cs_shift_vld); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (redir_vld !== 1'b1) $display("FAIL br0_rvld got %0b want 1", redir_vld); else pass_cnt++;
        chk_cnt++; if (redir_pc !== 21'h10) $display("FAIL br0_pc got %h want 10", redir_pc); else pass_cnt++;
        chk_cnt++;
        if ({sp_vld, sp_restore} !== {1'b1, 6'd3}) $display("FAIL br0_sp got %b/%0d want 1/3", sp_vld, sp_restore);
        else pass_cnt++;
        chk_cnt++; if (fs_ptr !== 7'd1) $display("FAIL br0_occ got %0d want 1", fs_ptr); else pass_cnt++;
    endtask

    task automatic test_block_br2();
        do_reset();
        send(OP_BLOCK, 6'd0, 1'b0, 1'b0, 21'h0, 21'h40, 6'd1);
        send(OP_BLOCK, 6'd0, 1'b0, 1'b0, 21'h0, 21'h30, 6'd2);
        send(OP_BLOCK, 6'd0, 1'b0, 1'b0, 21'h0, 21'h20, 6'd3);
        send(OP_BR, 6'd2, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk_cnt++;
            if ({cs_shift_vld, cs_pop, redir_vld} !== 3'b110)
                $display("FAIL br2_pop_t%0d got %b want 110", c, {cs_shift_vld, cs_pop, redir_vld});
            else pass_cnt++;
        end
        @(negedge clk);
        chk_cnt++; if (redir_vld !== 1'b1) $display("FAIL br2_rvld got %0b want 1", redir_vld); else pass_cnt++;
        chk_cnt++; if (redir_pc !== 21'h40) $display("FAIL br2_pc got %h want 40", redir_pc); else pass_cnt++;
        chk_cnt++; if (sp_restore !== 6'd1) $display("FAIL br2_sp got %0d want 1", sp_restore); else pass_cnt++;
        chk_cnt++; if (fs_ptr !== 7'd0) $display("FAIL br2_occ got %0d want 0", fs_ptr); else pass_cnt++;
    endtask

    task automatic test_call_return();
        logic [FRAME_W-1:0] exp_f;
        exp_f = {2'b01, 1'b1, 6'd4, 21'h55};
        do_reset();
        send(OP_CALL, 6'd0, 1'b0, 1'b1, 21'h55, 21'h200, 6'd4);
        @(negedge clk);
        chk_cnt++;
        if ({cs_push, cs_call} !== 2'b11) $display("FAIL call_strb got %b want 11", {cs_push, cs_call});
        else pass_cnt++;
        chk_cnt++; if (cs_push_data !== exp_f) $display("FAIL call_frame got %h want %h", cs_push_data, exp_f); else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({redir_vld, sp_vld, redir_pc} !== {1'b1, 1'b0, 21'h200})
            $display("FAIL call_redir got %b%b/%h want 10/200", redir_vld, sp_vld, redir_pc);
        else pass_cnt++;
        send(OP_BLOCK, 6'd0, 1'b0, 1'b0, 21'h0, 21'h99, 6'd7);
        send(OP_RETURN, 6'd0, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        chk_cnt++;
        if ({cs_shift_vld, cs_retu, cs_pop} !== 3'b110) $display("FAIL ret_strb got %b want 110", {cs_shift_vld, cs_retu, cs_pop});
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (redir_pc !== 21'h55) $display("FAIL ret_pc got %h want 55", redir_pc); else pass_cnt++;
        chk_cnt++;
        if ({sp_vld, sp_restore} !== {1'b1, 6'd5}) $display("FAIL ret_sp got %b/%0d want 1/5", sp_vld, sp_restore);
        else pass_cnt++;
        chk_cnt++; if (halt !== 1'b1) $display("FAIL ret_halt got %0b want 1", halt); else pass_cnt++;
        chk_cnt++; if (fs_ptr !== 7'd0) $display("FAIL ret_occ got %0d want 0", fs_ptr); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL halt_rdy got %0b want 0", in_rdy); else pass_cnt++;
    endtask

    task automatic test_if_end();
        logic [FRAME_W-1:0] exp_f;
        exp_f = {2'b10, 1'b0, 6'd2, 21'h80};
        do_reset();
        send(OP_IF, 6'd0, 1'b0, 1'b0, 21'h0, 21'h80, 6'd2);
        @(negedge clk);
        chk_cnt++; if (cs_push_data !== exp_f) $display("FAIL if_frame got %h want %h", cs_push_data, exp_f); else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({redir_vld, redir_pc} !== {1'b1, 21'h80}) $display("FAIL if_redir got %b/%h want 1/80", redir_vld, redir_pc);
        else pass_cnt++;
        send(OP_END, 6'd0, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        chk_cnt++; if (cs_pop !== 1'b1) $display("FAIL end_pop got %0b want 1", cs_pop); else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({redir_vld, halt, fs_ptr} !== {2'b00, 7'd0}) $display("FAIL end_after got %b%b/%0d want 00/0", redir_vld, halt, fs_ptr);
        else pass_cnt++;
    endtask

    task automatic test_brif();
        do_reset();
        send(OP_BLOCK, 6'd0, 1'b0, 1'b1, 21'h0, 21'h300, 6'd5);
        send(OP_LOOP, 6'd0, 1'b0, 1'b0, 21'h120, 21'h0, 6'd6);
        send(OP_BR_IF, 6'd1, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        chk_cnt++; if (cs_shift_vld !== 1'b0) $display("FAIL brif_nt_strb got %0b want 0", cs_shift_vld); else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({in_rdy, redir_vld} !== 2'b10) $display("FAIL brif_nt_after got %b want 10", {in_rdy, redir_vld});
        else pass_cnt++;
        send(OP_BR_IF, 6'd1, 1'b1, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({redir_vld, redir_pc, sp_restore} !== {1'b1, 21'h300, 6'd6})
            $display("FAIL brif_t got %b/%h/%0d want 1/300/6", redir_vld, redir_pc, sp_restore);
        else pass_cnt++;
        chk_cnt++; if (fs_ptr !== 7'd0) $display("FAIL brif_occ got %0d want 0", fs_ptr); else pass_cnt++;
    endtask

    task automatic test_errors();
        do_reset();
        send(OP_BLOCK, 6'd0, 1'b0, 1'b0, 21'h0, 21'h10, 6'd0);
        send(OP_BLOCK, 6'd0, 1'b0, 1'b0, 21'h0, 21'h20, 6'd0);
        @(negedge clk);
        chk_cnt++; if (err !== 1'b0) $display("FAIL err_clean got %0b want 0", err); else pass_cnt++;
        send(OP_BR, 6'd3, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        chk_cnt++;
        if ({err, in_rdy, cs_shift_vld} !== 3'b110) $display("FAIL err_br3 got %b want 110", {err, in_rdy, cs_shift_vld});
        else pass_cnt++;
        chk_cnt++; if (fs_ptr !== 7'd2) $display("FAIL err_br3_occ got %0d want 2", fs_ptr); else pass_cnt++;
        do_reset();
        send(OP_END, 6'd0, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        chk_cnt++;
        if ({err, in_rdy, cs_shift_vld} !== 3'b110) $display("FAIL err_end got %b want 110", {err, in_rdy, cs_shift_vld});
        else pass_cnt++;
        send(OP_BLOCK, 6'd0, 1'b0, 1'b0, 21'h0, 21'h10, 6'd0);
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({err, fs_ptr} !== {1'b1, 7'd1}) $display("FAIL err_sticky got %b/%0d want 1/1", err, fs_ptr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_unwind();
        do_reset();
        for (int i = 0; i < 5; i++) send(OP_BLOCK, 6'd0, 1'b0, 1'b0, 21'h0, 21'(i + 1), 6'(i));
        send(OP_BR, 6'd4, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        chk_cnt++; if (cs_pop !== 1'b1) $display("FAIL mid_pop1 got %0b want 1", cs_pop); else pass_cnt++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({cs_shift_vld, cs_pop, in_rdy, redir_vld, sp_vld, err} !== 6'b0)
            $display("FAIL mid_rst_outs got %b want 000000", {cs_shift_vld, cs_pop, in_rdy, redir_vld, sp_vld, err});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        // occ must be back at zero: end now underflows
        send(OP_END, 6'd0, 1'b0, 1'b0, 21'h0, 21'h0, 6'd0);
        @(negedge clk);
        chk_cnt++;
        if ({err, cs_shift_vld} !== 2'b10) $display("FAIL mid_occ0 got %b want 10", {err, cs_shift_vld});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_loop_br0();
        test_block_br2();
        test_call_return();
        test_if_end();
        test_brif();
        test_errors();
        test_reset_mid_unwind();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
